// File: rtl/cache_miss_controller_if.sv
// Bus bundle between the miss controller and its CPU, cache lookup, memory and fill ports.
// The master modport is the controller view; slave is the surrounding environment.
interface cache_miss_controller_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned TAG_W  = 28;
  localparam int unsigned CNT_W  = 16;

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ready;
  logic              cpu_valid;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_hit;
  logic              cpu_error;

  logic              search_cache;
  logic [ADDR_W-1:0] address;
  logic              search_done;
  logic              hit;
  logic [DATA_W-1:0] data;
  logic [TAG_W-1:0]  tag_out;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;

  logic              fill_en;
  logic [TAG_W-1:0]  fill_tag;
  logic [DATA_W-1:0] fill_data;

  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  modport master (
    input  cpu_req, cpu_addr, search_done, hit, data, tag_out, mem_ack, mem_data,
    output cpu_ready, cpu_valid, cpu_data, cpu_hit, cpu_error,
           search_cache, address, mem_req, mem_addr,
           fill_en, fill_tag, fill_data, hit_count, miss_count
  );

  modport slave (
    output cpu_req, cpu_addr, search_done, hit, data, tag_out, mem_ack, mem_data,
    input  cpu_ready, cpu_valid, cpu_data, cpu_hit, cpu_error,
           search_cache, address, mem_req, mem_addr,
           fill_en, fill_tag, fill_data, hit_count, miss_count
  );
endinterface

// File: rtl/cache_miss_controller.sv
// Single-outstanding read controller: cache lookup, memory fetch and cache fill on miss,
// lookup timeout reporting, and saturating hit/miss statistics. All outputs are registered.
module cache_miss_controller #(
  parameter int unsigned LOOKUP_TIMEOUT = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  cache_miss_controller_if.master bus
);
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned TAG_W   = 28;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMER_W = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WAIT, S_MEM, S_FILL, S_RESPOND
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   mem_buf;
  logic [DATA_W-1:0]   resp_data;
  logic                resp_hit;
  logic                resp_err;
  logic                ready_q;
  logic                valid_q;
  logic                search_q;
  logic                mem_req_q;
  logic                fill_q;
  logic [TIMER_W-1:0]  timer;
  logic [CNT_W-1:0]    hit_cnt;
  logic [CNT_W-1:0]    miss_cnt;
  logic                eff_hit_c;

  // A hit only counts when the returned tag matches the request, not just the hit flag.
  assign eff_hit_c = bus.search_done && bus.hit && (bus.tag_out == req_addr[TAG_W-1:0]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      req_addr  <= '0;
      mem_buf   <= '0;
      resp_data <= '0;
      resp_hit  <= 1'b0;
      resp_err  <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      search_q  <= 1'b0;
      mem_req_q <= 1'b0;
      fill_q    <= 1'b0;
      timer     <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cpu_req) begin
            req_addr  <= bus.cpu_addr;
            resp_data <= '0;
            resp_hit  <= 1'b0;
            resp_err  <= 1'b0;
            ready_q   <= 1'b0;
            search_q  <= 1'b1;
            state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          search_q <= 1'b0;
          timer    <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          // search_done has priority over a timeout landing on the same edge.
          if (eff_hit_c) begin
            resp_data <= bus.data;
            resp_hit  <= 1'b1;
            valid_q   <= 1'b1;
            if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
            state     <= S_RESPOND;
          end else if (bus.search_done) begin
            mem_req_q <= 1'b1;
            state     <= S_MEM;
          end else if (timer == TIMER_W'(LOOKUP_TIMEOUT - 1)) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
            valid_q   <= 1'b1;
            state     <= S_RESPOND;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        S_MEM: begin
          if (bus.mem_ack) begin
            mem_buf   <= bus.mem_data;
            mem_req_q <= 1'b0;
            fill_q    <= 1'b1;
            if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
            state     <= S_FILL;
          end
        end
        S_FILL: begin
          fill_q    <= 1'b0;
          resp_data <= mem_buf;
          resp_hit  <= 1'b0;
          valid_q   <= 1'b1;
          state     <= S_RESPOND;
        end
        S_RESPOND: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cpu_ready    = ready_q;
  assign bus.cpu_valid    = valid_q;
  assign bus.cpu_data     = resp_data;
  assign bus.cpu_hit      = resp_hit;
  assign bus.cpu_error    = resp_err;
  assign bus.search_cache = search_q;
  assign bus.address      = req_addr;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_addr     = req_addr;
  assign bus.fill_en      = fill_q;
  assign bus.fill_tag     = req_addr[TAG_W-1:0];
  assign bus.fill_data    = mem_buf;
  assign bus.hit_count    = hit_cnt;
  assign bus.miss_count   = miss_cnt;
endmodule

// File: doc/cache_miss_controller.md
# cache_miss_controller

Request controller sitting directly in front of the `Cache` lookup block. Accepts one CPU read at a time, issues a single-cycle `search_cache` lookup, and returns cache data on a hit. On a miss it fetches the line from backing memory, writes it into the cache through a fill port, then returns it. It also keeps saturating hit/miss statistics.

## Interface
Parameters:
- `LOOKUP_TIMEOUT`, default 8: max cycles to wait for `search_done` before flagging an error (range 1..255).

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  read request, sampled only when `cpu_ready`=1.
- `cpu_addr`  in  32  request address, captured with `cpu_req`.
- `cpu_ready`  out  1  controller idle, can accept a request.
- `cpu_valid`  out  1  one-cycle response strobe.
- `cpu_data`  out  64  response data, valid with `cpu_valid`.
- `cpu_hit`  out  1  1 = served from cache, 0 = served from memory.
- `cpu_error`  out  1  lookup timed out, valid with `cpu_valid`.
- `search_cache`  out  1  one-cycle lookup strobe to cache.
- `address`  out  32  lookup address to cache.
- `search_done`  in  1  cache lookup complete.
- `hit`  in  1  cache hit, valid with `search_done`.
- `data`  in  64  cache data, valid with `search_done`.
- `tag_out`  in  28  cache tag, valid with `search_done`. Unused except in the hit check below.
- `mem_req`  out  1  memory read request, level, held until `mem_ack`.
- `mem_addr`  out  32  memory read address.
- `mem_ack`  in  1  memory data valid. Single-cycle, only honoured while `mem_req`=1.
- `mem_data`  in  64  memory read data.
- `fill_en`  out  1  one-cycle cache fill strobe.
- `fill_tag`  out  28  fill tag, equals `cpu_addr[27:0]` of the request.
- `fill_data`  out  64  fill data.
- `hit_count`  out  16  saturating count of cache hits.
- `miss_count`  out  16  saturating count of misses serviced from memory.

## Operation
- FSM states: IDLE, LOOKUP, WAIT, MEM, FILL, RESPOND.
- **IDLE**
  - `cpu_ready`=1.
  - `cpu_req`=1 at a clock edge: latch `cpu_addr` into the request register, go to LOOKUP.
- **LOOKUP**
  - One cycle: `search_cache`=1, `address`=latched address.
  - Clear the timeout counter, go to WAIT.
- **WAIT**
  - `search_done` is sampled only in this state. A `search_done` during LOOKUP is ignored.
  - Effective hit = `search_done`=1, `hit`=1 and `tag_out`==latched `[27:0]`.
  - Effective hit: latch `data`, set response hit, increment `hit_count`, go to RESPOND.
  - `search_done`=1 without an effective hit: go to MEM.
  - Timeout counter reaches `LOOKUP_TIMEOUT` without `search_done`: response data = 0, error = 1, go to RESPOND.
  - Neither counter nor any other statistic changes on timeout.
- **MEM**
  - `mem_req`=1, `mem_addr`=latched address.
  - On `mem_ack`: latch `mem_data`, increment `miss_count`, go to FILL.
  - No timeout in this state.
- **FILL**
  - One cycle: `fill_en`=1, `fill_tag`=latched `[27:0]`, `fill_data`=latched memory data.
  - Go to RESPOND.
- **RESPOND**
  - One cycle: `cpu_valid`=1 with `cpu_data`, `cpu_hit` and `cpu_error` from the latched result.
  - Go to IDLE.
- `cpu_req` outside IDLE is ignored; no queueing.
- Counters saturate at 16'hFFFF and never wrap.
- Reset (async, `reset`=0) from any state:
  - FSM returns to IDLE.
  - All registers clear.
  - `mem_req`, `fill_en` and `search_cache` drop immediately, with no clock edge needed.
  - An in-flight request is discarded with no `cpu_valid`.
  - A `mem_ack` arriving after reset is ignored.

## Timing
- Reset values:
  - `cpu_ready`=1.
  - All other outputs 0: `cpu_valid`, `cpu_data`, `cpu_hit`, `cpu_error`, `search_cache`, `address`, `mem_req`, `mem_addr`, `fill_en`, `fill_tag`, `fill_data`, `hit_count`, `miss_count`.
- All outputs are registered or decoded from the FSM state. There is no combinational path from inputs to outputs.
- Hit path:
  - Request accepted at edge E0.
  - `search_cache` is high in cycle E0→E1.
  - If `search_done` is first sampled at edge Ek, `cpu_valid` is high in cycle Ek→Ek+1.
  - With a 2-cycle cache response, `cpu_valid` is high 4 cycles after acceptance.
- Miss path:
  - `mem_req` rises the cycle after the `search_done` edge.
  - `mem_ack` sampled at edge Em: `fill_en` high in cycle Em→Em+1, `cpu_valid` high in cycle Em+1→Em+2.
  - `mem_ack` coincident with the `mem_req` rising edge is not possible: `mem_ack` is sampled only in MEM.
- Timeout: `cpu_valid` with `cpu_error`=1 is asserted `LOOKUP_TIMEOUT`+1 cycles after LOOKUP.
- Back-to-back: the earliest next acceptance is the IDLE cycle after RESPOND, so `cpu_ready` is low from acceptance through RESPOND.

## Test plan
- **Hit at 255.** Cache model warmed with tags 0..511, data = tag². `cpu_req`, addr 255 → exactly one `search_cache` pulse with `address`=255; `cpu_valid` with `cpu_data`=65025, `cpu_hit`=1, `cpu_error`=0; `hit_count`=1; no `mem_req`.
- **Miss at 1023.** `mem_ack` delayed 5 cycles, `mem_data`=1046529 → `mem_req` held with `mem_addr`=1023 until ack; `fill_en` one cycle with `fill_tag`=1023, `fill_data`=1046529; then `cpu_valid`, `cpu_hit`=0, `cpu_data`=1046529; `miss_count`=1.
- **Lookup timeout.** Cache never asserts `search_done` (`LOOKUP_TIMEOUT`=8) → `cpu_valid`=1, `cpu_error`=1, `cpu_data`=0 exactly 9 cycles after the `search_cache` cycle; counters unchanged.
- **Busy and back-to-back.** Second `cpu_req` (addr 0) held high during a miss → ignored while `cpu_ready`=0; accepted on the first IDLE cycle after RESPOND; returns data 0, hit.
- **Reset mid-miss.** `reset` driven low while in MEM → `mem_req` falls without a clock edge, no `cpu_valid`, counters 0; a late `mem_ack` is ignored; the next request (addr 511) returns 261121, hit.
- **Saturation.** Preload `hit_count` to 16'hFFFE via forced state, then 3 hits → count stops at 16'hFFFF.
